change_dispenser: RTL and testbench

- Downstream of the soda vending controller. Consumes its one-cycle `soda`/`change` result and drives the physical actuators.
- Per vend: one soda-release pulse, then one nickel-eject pulse per unit of `change`.
- Each nickel is confirmed by a coin-drop sensor; a missing confirmation times out into a sticky fault.
- A small request FIFO absorbs back-to-back vends while the actuators are busy.

---
 rtl/change_dispenser.sv | 167 ++++++++++++++++
 tb/tb_change_dispenser.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Queues vend requests and drives soda/nickel actuators; vend starts 1 cycle after an idle request.
// Full FIFO drops requests with an overflow pulse; CHANGE_DISPENSER_COUNT_EN adds coins_out_o drop counter.
module change_dispenser #(
  parameter int DEPTH     = 4,
  parameter int CHG_W     = 3,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   soda_i,
  input  logic [CHG_W-1:0]       change_i,
  input  logic                   drop_i,
  output logic                   vend_o,
  output logic                   nickle_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   fault_o,
`ifdef CHANGE_DISPENSER_COUNT_EN
  output logic [15:0]            coins_out_o,
`endif
  output logic [$clog2(DEPTH):0] pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_VEND, S_EJECT, S_WAIT, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [CHG_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             got_q, got_d;
  logic             drop_cnt;

  logic [CHG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  // A pop on the same edge frees a slot, so a full FIFO still accepts then.
  assign push = soda_i && ((count_q != FULL) || pop);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= change_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow_o <= soda_i && !push;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      got_q   <= got_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    got_d    = got_q;
    drop_cnt = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          rem_d   = mem_q[rd_ptr_q];
          pcnt_d  = '0;
          state_d = S_VEND;
        end
      end
      S_VEND: begin
        if (pcnt_q == P_LAST) begin
          pcnt_d  = '0;
          got_d   = 1'b0;
          state_d = (rem_q == '0) ? S_IDLE : S_EJECT;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_EJECT: begin
        // An early drop confirms this coin; the pulse still runs to full length.
        if (drop_i && !got_q) begin
          drop_cnt = 1'b1;
          rem_d    = rem_q - 1'b1;
          got_d    = 1'b1;
        end
        if (pcnt_q == P_LAST) begin
          pcnt_d = '0;
          got_d  = 1'b0;
          if (got_q || drop_cnt) begin
            state_d = (rem_d == '0) ? S_IDLE : S_EJECT;
          end else begin
            tcnt_d  = '0;
            state_d = S_WAIT;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (drop_i) begin
          drop_cnt = 1'b1;
          rem_d    = rem_q - 1'b1;
          pcnt_d   = '0;
          got_d    = 1'b0;
          state_d  = (rem_q == CHG_W'(1)) ? S_IDLE : S_EJECT;
        end else if (tcnt_q == T_LAST) begin
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign vend_o    = (state_q == S_VEND);
  assign nickle_o  = (state_q == S_EJECT);
  assign fault_o   = (state_q == S_FAULT);
  assign busy_o    = (state_q != S_IDLE) || (count_q != '0);
  assign pending_o = count_q;

`ifdef CHANGE_DISPENSER_COUNT_EN
  logic [15:0] coins_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coins_q <= '0;
    end else if (drop_cnt && (coins_q != 16'hFFFF)) begin
      coins_q <= coins_q + 16'd1;
    end
  end

  assign coins_out_o = coins_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of single vends plus corner sequences.
module tb_change_dispenser;
  localparam int PL = 4;
  localparam int TO = 255;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       soda_i = 1'b0;
  logic [2:0] change_i = '0;
  logic       drop_i = 1'b0;
  logic       vend_o, nickle_o, busy_o, overflow_o, fault_o;
  logic [2:0] pending_o;
`ifdef CHANGE_DISPENSER_COUNT_EN
  logic [15:0] coins_out_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_coins = 0;

  typedef struct {
    logic [2:0] chg;
    int         gap;
    int         exp_vstart;
    int         exp_vcyc;
    int         exp_npulse;
    int         exp_ncyc;
  } vec_t;

  change_dispenser dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .soda_i     (soda_i),
    .change_i   (change_i),
    .drop_i     (drop_i),
    .vend_o     (vend_o),
    .nickle_o   (nickle_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .fault_o    (fault_o),
`ifdef CHANGE_DISPENSER_COUNT_EN
    .coins_out_o(coins_out_o),
`endif
    .pending_o  (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    soda_i = 1'b0;
    drop_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    exp_coins = 0;
  endtask

  task automatic add_coins(input int n);
    exp_coins = (exp_coins + n > 65535) ? 65535 : exp_coins + n;
  endtask

  // One vend from idle; drop_i given gap cycles after each nickel falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    int vstart, vcyc, np, ncyc, badlen, run, since, ovf;
    logic pn, done;
    vstart = -1; vcyc = 0; np = 0; ncyc = 0; badlen = 0; run = 0;
    since = -1; ovf = 0; pn = 1'b0; done = 1'b0;
    soda_i = 1'b1;
    change_i = v.chg;
    step();
    soda_i = 1'b0;
    change_i = '0;
    chk($sformatf("v%0d_pend_push", idx), pending_o, 1);
    chk($sformatf("v%0d_vend_T0", idx), vend_o, 0);
    for (int c = 1; c <= 3000 && !done; c++) begin
      step();
      drop_i = 1'b0;
      if (vend_o) begin
        if (vstart < 0) vstart = c;
        vcyc++;
      end
      if (nickle_o) begin
        ncyc++;
        run++;
        if (!pn) np++;
      end
      if (pn && !nickle_o) begin
        if (run != PL) badlen++;
        run = 0;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (since == v.gap) begin
        drop_i = 1'b1;
        since = -1;
      end
      if (overflow_o) ovf++;
      pn = nickle_o;
      if (!busy_o) done = 1'b1;
    end
    drop_i = 1'b0;
    add_coins(int'(v.chg));
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_vstart", idx), vstart, v.exp_vstart);
    chk($sformatf("v%0d_vcyc", idx), vcyc, v.exp_vcyc);
    chk($sformatf("v%0d_npulse", idx), np, v.exp_npulse);
    chk($sformatf("v%0d_ncyc", idx), ncyc, v.exp_ncyc);
    chk($sformatf("v%0d_badlen", idx), badlen, 0);
    chk($sformatf("v%0d_fault", idx), fault_o, 0);
    chk($sformatf("v%0d_ovf", idx), ovf, 0);
    chk($sformatf("v%0d_pend_end", idx), pending_o, 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
    chk($sformatf("v%0d_coins", idx), coins_out_o, exp_coins);
`endif
  endtask

  task automatic wait_nickle(input string name);
    logic seen;
    seen = nickle_o;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      seen = nickle_o;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    vec_t vecs[4];
    logic [5:0] ovf_pat;
    int run, n, since;
    logic done;

    vecs[0] = '{chg: 3'd0, gap: 2,  exp_vstart: 1, exp_vcyc: PL, exp_npulse: 0, exp_ncyc: 0};
    vecs[1] = '{chg: 3'd3, gap: 2,  exp_vstart: 1, exp_vcyc: PL, exp_npulse: 3, exp_ncyc: 3*PL};
    vecs[2] = '{chg: 3'd7, gap: 0,  exp_vstart: 1, exp_vcyc: PL, exp_npulse: 7, exp_ncyc: 7*PL};
    vecs[3] = '{chg: 3'd1, gap: 10, exp_vstart: 1, exp_vcyc: PL, exp_npulse: 1, exp_ncyc: PL};

    // Reset state, sampled while reset is held.
    step();
    step();
    chk("rst_vend", vend_o, 0);
    chk("rst_nickle", nickle_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_pend", pending_o, 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
    chk("rst_coins", coins_out_o, 0);
`endif
    rst_ni = 1'b1;
    step();
    chk("post_rst_busy", busy_o, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Drop during the second EJECT cycle: the two nickel pulses merge back to back.
    soda_i = 1'b1;
    change_i = 3'd2;
    step();
    soda_i = 1'b0;
    change_i = '0;
    wait_nickle("early_first_eject");
    run = 1;
    step();
    if (nickle_o) run++;
    drop_i = 1'b1;
    step();
    drop_i = 1'b0;
    for (int c = 0; c < 40 && nickle_o; c++) begin
      run++;
      step();
    end
    chk("early_merged_len", run, 2*PL);
    since = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      drop_i = 1'b0;
      since++;
      if (since == 2) drop_i = 1'b1;
      if (!busy_o) done = 1'b1;
    end
    drop_i = 1'b0;
    add_coins(2);
    chk("early_done", done, 1);
    chk("early_fault", fault_o, 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
    chk("early_coins", coins_out_o, exp_coins);
`endif

    // Burst with no drops. The first request pops on the second edge, so the
    // sixth consecutive request is the first to find the FIFO full.
    do_reset();
    ovf_pat = '0;
    soda_i = 1'b1;
    change_i = 3'd1;
    for (int k = 0; k < 6; k++) begin
      step();
      ovf_pat[k] = overflow_o;
    end
    soda_i = 1'b0;
    change_i = '0;
    chk("burst_ovf_pat", ovf_pat, 6'b100000);
    chk("burst_pend", pending_o, 4);
    step();
    chk("burst_ovf_clear", overflow_o, 0);
    wait_nickle("burst_eject");
    for (int c = 0; c < 20 && nickle_o; c++) step();
    chk("burst_in_wait", nickle_o, 0);
    n = 0;
    for (int c = 0; c < 400 && !fault_o; c++) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("fault_pend", pending_o, 4);
    chk("fault_busy", busy_o, 1);
    drop_i = 1'b1;
    step();
    drop_i = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("fault_sticky", fault_o, 1);
    chk("fault_pend_hold", pending_o, 4);
    chk("fault_vend", vend_o, 0);
    chk("fault_nickle", nickle_o, 0);

    // Asynchronous reset in the middle of a nickel pulse.
    do_reset();
    soda_i = 1'b1;
    change_i = 3'd1;
    step();
    step();
    soda_i = 1'b0;
    change_i = '0;
    wait_nickle("arst_eject");
    step();
    chk("arst_pend_before", pending_o, 1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_nickle", nickle_o, 0);
    chk("arst_pend", pending_o, 0);
    step();
    rst_ni = 1'b1;
    exp_coins = 0;
    step();
    chk("arst_busy", busy_o, 0);
    chk("arst_vend", vend_o, 0);
    chk("arst_fault", fault_o, 0);
    chk("arst_pend_after", pending_o, 0);

`ifdef CHANGE_DISPENSER_COUNT_EN
    // Counter saturation from a preloaded value.
    force dut.coins_q = 16'hFFFE;
    step();
    release dut.coins_q;
    exp_coins = 65534;
    chk("sat_preload", coins_out_o, 16'hFFFE);
    run_vec(vecs[1], 9);
    chk("sat_value", coins_out_o, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
